// File: rtl/custcounter_seq.sv
// ---------------------------------------------------------------------------
// custcounter_seq
//
// Sequencer for an alternating add/subtract counter. The host programs an
// add step, a subtract step and a run length, then pulses start. The block
// runs that many steps, alternating add and subtract and starting with add,
// then pulses done for one cycle. Pause holds a run without stepping, and
// abort drops back to idle without a done pulse.
//
// Build option:
//   CUSTCOUNTER_SEQ_SAT_EN  defined   -> add clamps at all-ones, subtract
//                                        clamps at zero
//                           undefined -> modulo 2^WIDTH wrap (default)
//
// Parameters:
//   WIDTH  accumulator and step width
//   LEN_W  run-length counter width
//   INIT   accumulator value loaded at reset and at every accepted start
//
// Ports:
//   clk      in   clock, all state updates on rising edge
//   reset    in   asynchronous active-high reset
//   i_start  in   start request, only honoured in IDLE
//   i_inc    in   add step, latched on accepted start
//   i_dec    in   subtract step, latched on accepted start
//   i_len    in   number of steps, latched on accepted start
//   i_pause  in   hold RUN without stepping
//   i_abort  in   leave RUN without done (has priority over pause)
//   o_count  out  accumulator value (registered)
//   o_busy   out  high while in RUN (registered)
//   o_done   out  one-cycle pulse after the last step (registered)
//   o_phase  out  next operation: 1 = add, 0 = subtract (registered)
// ---------------------------------------------------------------------------
module custcounter_seq #(
   parameter int               WIDTH = 8,
   parameter int               LEN_W = 8,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_inc,
   input  logic [WIDTH-1:0] i_dec,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_pause,
   input  logic             i_abort,
   output logic [WIDTH-1:0] o_count,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_phase
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic [WIDTH-1:0] inc_q;
   logic [WIDTH-1:0] dec_q;
   logic [LEN_W-1:0] remaining;

   logic [WIDTH-1:0] count_nxt;
   logic [WIDTH-1:0] inc_nxt;
   logic [WIDTH-1:0] dec_nxt;
   logic [LEN_W-1:0] remaining_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic             phase_nxt;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] add_val;
   logic [WIDTH-1:0] sub_val;
   logic             last_step;
   logic             step_en;

   // The remaining counter is loaded with the run length and counts down to
   // one; the step taken while it reads one is the final step. Because it
   // never has to reach zero mid-run, the maximum length fits without wrap.
   assign last_step = (remaining == LEN_W'(1));
   assign step_en   = (state == RUN) && !i_abort && !i_pause;

   // Step arithmetic, one bit wider so the carry or borrow is visible. The
   // extra bit is either dropped (wrap) or used to clamp (saturate).
   always_comb begin
      sum  = {1'b0, o_count} + {1'b0, inc_q};
      diff = {1'b0, o_count} - {1'b0, dec_q};
`ifdef CUSTCOUNTER_SEQ_SAT_EN
      add_val = sum[WIDTH]  ? '1 : sum[WIDTH-1:0];
      sub_val = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
      add_val = sum[WIDTH-1:0];
      sub_val = diff[WIDTH-1:0];
`endif
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. Abort beats pause, pause beats stepping. A zero
   // length start skips RUN entirely. DONE always lasts a single cycle, so
   // a start seen there is simply dropped.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (i_start) begin
               next_state = (i_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (i_abort) begin
               next_state = IDLE;
            end else if (!i_pause && last_step) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Next values of every registered output and of the datapath. Everything
   // holds by default; done is a pulse, so it defaults low.
   always_comb begin
      count_nxt     = o_count;
      inc_nxt       = inc_q;
      dec_nxt       = dec_q;
      remaining_nxt = remaining;
      busy_nxt      = o_busy;
      done_nxt      = 1'b0;
      phase_nxt     = o_phase;
      unique case (state)
         IDLE: begin
            if (i_start) begin
               inc_nxt       = i_inc;
               dec_nxt       = i_dec;
               remaining_nxt = i_len;
               count_nxt     = INIT;
               phase_nxt     = 1'b1;
               busy_nxt      = (i_len != '0);
               done_nxt      = (i_len == '0);
            end
         end
         RUN: begin
            if (i_abort) begin
               busy_nxt = 1'b0;
            end else if (step_en) begin
               count_nxt     = o_phase ? add_val : sub_val;
               phase_nxt     = ~o_phase;
               remaining_nxt = remaining - LEN_W'(1);
               if (last_step) begin
                  busy_nxt = 1'b0;
                  done_nxt = 1'b1;
               end
            end
         end
         DONE: begin
            busy_nxt = 1'b0;
         end
         default: begin
            busy_nxt = 1'b0;
         end
      endcase
   end

   // Output and datapath registers. Reset returns everything to the idle
   // values at once, even in the middle of a run.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_count   <= INIT;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_phase   <= 1'b1;
         inc_q     <= '0;
         dec_q     <= '0;
         remaining <= '0;
      end else begin
         o_count   <= count_nxt;
         o_busy    <= busy_nxt;
         o_done    <= done_nxt;
         o_phase   <= phase_nxt;
         inc_q     <= inc_nxt;
         dec_q     <= dec_nxt;
         remaining <= remaining_nxt;
      end
   end

endmodule

// File: tb/tb_custcounter_seq.sv
// ---------------------------------------------------------------------------
// tb_custcounter_seq
//
// Directed bench for custcounter_seq with default parameters (WIDTH=8,
// LEN_W=8, INIT=0). Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, so every check sees the result of the edge
// just taken.
// ---------------------------------------------------------------------------
module tb_custcounter_seq;

   logic       clk;
   logic       reset;
   logic       i_start;
   logic [7:0] i_inc;
   logic [7:0] i_dec;
   logic [7:0] i_len;
   logic       i_pause;
   logic       i_abort;
   logic [7:0] o_count;
   logic       o_busy;
   logic       o_done;
   logic       o_phase;

   int checkCount;
   int passCount;

   custcounter_seq #(
      .WIDTH(8),
      .LEN_W(8),
      .INIT (8'd0)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .i_start(i_start),
      .i_inc  (i_inc),
      .i_dec  (i_dec),
      .i_len  (i_len),
      .i_pause(i_pause),
      .i_abort(i_abort),
      .o_count(o_count),
      .o_busy (o_busy),
      .o_done (o_done),
      .o_phase(o_phase)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Check all four outputs against one expected vector.
   task automatic checkAll(input string tag, input logic [7:0] cnt,
                           input logic busy, input logic done,
                           input logic phase);
      checkOutput({tag, ".count"}, 32'(o_count), 32'(cnt));
      checkOutput({tag, ".busy"},  32'(o_busy),  32'(busy));
      checkOutput({tag, ".done"},  32'(o_done),  32'(done));
      checkOutput({tag, ".phase"}, 32'(o_phase), 32'(phase));
   endtask

   // Present a start with the given program for exactly one edge.
   task automatic startRun(input logic [7:0] inc, input logic [7:0] dec,
                           input logic [7:0] len);
      i_inc   = inc;
      i_dec   = dec;
      i_len   = len;
      i_start = 1'b1;
      applyStimulus();
      i_start = 1'b0;
   endtask

   logic [7:0] expCount [4];
   logic [7:0] satThird;

   initial begin
      checkCount = 0;
      passCount  = 0;
      reset   = 1'b1;
      i_start = 1'b0;
      i_inc   = '0;
      i_dec   = '0;
      i_len   = '0;
      i_pause = 1'b0;
      i_abort = 1'b0;

      // Reset state.
      #2;
      checkAll("reset", 8'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
      applyStimulus();

      // Basic run: +5/-2 for four steps gives 5,3,8,6.
      expCount = '{8'd5, 8'd3, 8'd8, 8'd6};
      startRun(8'd5, 8'd2, 8'd4);
      checkAll("t1.start", 8'd0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         applyStimulus();
         checkAll($sformatf("t1.step%0d", k + 1), expCount[k],
                  (k != 3), (k == 3), (k % 2 == 1));
      end
      applyStimulus();
      checkAll("t1.idle", 8'd6, 1'b0, 1'b0, 1'b1);

      // Carry out of the accumulator: wrap or clamp on the third step.
`ifdef CUSTCOUNTER_SEQ_SAT_EN
      satThird = 8'd255;
`else
      satThird = 8'd143;
`endif
      startRun(8'd200, 8'd1, 8'd3);
      applyStimulus();
      checkOutput("t2.step1", 32'(o_count), 32'd200);
      applyStimulus();
      checkOutput("t2.step2", 32'(o_count), 32'd199);
      applyStimulus();
      checkAll("t2.step3", satThird, 1'b0, 1'b1, 1'b0);
      applyStimulus();

      // Pause for three cycles after the second step.
      startRun(8'd5, 8'd2, 8'd4);
      applyStimulus();
      applyStimulus();
      checkOutput("t3.step2", 32'(o_count), 32'd3);
      i_pause = 1'b1;
      for (int k = 0; k < 3; k++) begin
         applyStimulus();
         checkAll($sformatf("t3.hold%0d", k), 8'd3, 1'b1, 1'b0, 1'b1);
      end
      i_pause = 1'b0;
      applyStimulus();
      checkAll("t3.step3", 8'd8, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      checkAll("t3.step4", 8'd6, 1'b0, 1'b1, 1'b1);
      applyStimulus();

      // Abort after the third step, then a fresh one-step run.
      startRun(8'd5, 8'd2, 8'd4);
      applyStimulus();
      applyStimulus();
      applyStimulus();
      checkOutput("t4.step3", 32'(o_count), 32'd8);
      i_abort = 1'b1;
      applyStimulus();
      i_abort = 1'b0;
      checkOutput("t4.abort.count", 32'(o_count), 32'd8);
      checkOutput("t4.abort.busy",  32'(o_busy),  32'd0);
      checkOutput("t4.abort.done",  32'(o_done),  32'd0);
      applyStimulus();
      checkOutput("t4.after.done",  32'(o_done),  32'd0);
      checkOutput("t4.after.count", 32'(o_count), 32'd8);
      startRun(8'd1, 8'd9, 8'd1);
      checkAll("t4.restart", 8'd0, 1'b1, 1'b0, 1'b1);
      applyStimulus();
      checkAll("t4.single", 8'd1, 1'b0, 1'b1, 1'b0);
      applyStimulus();

      // Zero length with start held: done at once, start ignored in DONE.
      i_inc   = 8'd7;
      i_dec   = 8'd3;
      i_len   = 8'd0;
      i_start = 1'b1;
      applyStimulus();
      checkAll("t5.len0", 8'd0, 1'b0, 1'b1, 1'b1);
      i_len = 8'd2;
      applyStimulus();
      checkAll("t5.indone", 8'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus();
      i_start = 1'b0;
      checkAll("t5.reaccept", 8'd0, 1'b1, 1'b0, 1'b1);
      applyStimulus();
      checkOutput("t5.step1", 32'(o_count), 32'd7);
      applyStimulus();
      checkAll("t5.step2", 8'd4, 1'b0, 1'b1, 1'b1);
      applyStimulus();

      // Asynchronous reset between edges in the middle of a run.
      startRun(8'd5, 8'd2, 8'd4);
      applyStimulus();
      checkOutput("t6.step1", 32'(o_count), 32'd5);
      #2;
      reset = 1'b1;
      #1;
      checkAll("t6.async", 8'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus();
      checkAll("t6.held", 8'd0, 1'b0, 1'b0, 1'b1);
      reset = 1'b0;
      applyStimulus();
      checkAll("t6.release", 8'd0, 1'b0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/custcounter_seq.md
Name: custcounter_seq

Overview:
- Sequencer for the alternating add/subtract counter datapath: one 8-bit accumulator, add on even steps, subtract on odd steps.
- Host writes add step, subtract step and run length, then pulses start. The block runs the programmed number of steps, then pulses done.
- Sits between the host/control logic and the counter output. It replaces fixed +5/-2 behaviour with programmed, bounded runs under a start/busy/done handshake.

Parameters:
- WIDTH, 8, accumulator and step width
- LEN_W, 8, run-length counter width
- INIT, 0, accumulator value loaded at reset and at every accepted start

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- i_start  input  1  start request, sampled only in IDLE
- i_inc  input  WIDTH  add step, latched on accepted start
- i_dec  input  WIDTH  subtract step, latched on accepted start
- i_len  input  LEN_W  number of steps, latched on accepted start
- i_pause  input  1  hold RUN without stepping
- i_abort  input  1  terminate RUN without done
- o_count  output  WIDTH  accumulator value, registered
- o_busy  output  1  high while in RUN
- o_done  output  1  one-cycle pulse after the last step
- o_phase  output  1  next operation: 1 = add, 0 = subtract

Behaviour:
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset (asynchronous, applied immediately, any state including mid-run):
  - state IDLE; o_count=INIT; o_busy=0; o_done=0; o_phase=1.
  - step index and remaining count cleared; latched steps cleared.
- IDLE:
  - i_start=1 at edge E: latch i_inc, i_dec and i_len; set o_count=INIT and o_phase=1.
  - If i_len!=0: go to RUN, o_busy=1.
  - If i_len==0: go directly to DONE, o_done=1; o_count=INIT.
- RUN, per edge, evaluated in priority order:
  - i_abort=1: go to IDLE; o_busy=0; o_count holds; no o_done.
  - i_pause=1: all state and outputs hold.
  - Otherwise, one step:
    - o_phase=1: o_count += inc. o_phase=0: o_count -= dec.
    - Toggle o_phase; decrement remaining.
    - If this was the last step: go to DONE, o_busy=0, o_done=1.
- Timing: start sampled at edge 0, steps at edges 1..len (no pauses), o_done high for the cycle after edge len, back in IDLE after edge len+1.
- DONE: lasts exactly one cycle; o_done clears and the state returns to IDLE. i_start in DONE is ignored, not queued.
- i_start in RUN or DONE is ignored. Latched steps and length cannot change mid-run.
- Arithmetic is modulo 2^WIDTH: add carry and subtract borrow are discarded.
- o_count holds its final value in IDLE until the next accepted start or reset.
- Length counter: i_len = 2^LEN_W-1 runs the full count without wrapping the remaining counter.

Optional Feature:
- Macro CUSTCOUNTER_SEQ_SAT_EN.
- Defined: arithmetic saturates. Add clamps at 2^WIDTH-1; subtract clamps at 0. Stepping continues normally otherwise.
- Undefined: modulo wrap as described in Behaviour.
- Handshake and timing are identical in both builds.

Test Plan:
- inc=5, dec=2, len=4, INIT=0, start -> o_count 5,3,8,6 on edges 1-4; o_busy high for edges 1-4; o_done high in the cycle after edge 4; final o_count 6.
- inc=200, dec=1, len=3 -> wrap build: 200,199,143. SAT build: 200,199,255.
- inc=5, dec=2, len=4; i_pause high for 3 cycles after step 2 -> o_count holds at 3 for 3 cycles, then 8,6; done is delayed by 3 cycles.
- Abort after step 3 (o_count=8) -> o_busy drops, o_count stays 8, no o_done. Next start with len=1 inc=1 -> o_count INIT+1 = 1.
- len=0 start -> no o_busy, o_done pulse one cycle after start, o_count=INIT. i_start held high through DONE -> ignored there, re-accepted only once back in IDLE.
- Reset asserted asynchronously mid-RUN (between edges) -> outputs go immediately to o_count=INIT, o_busy=0, o_done=0, o_phase=1; no step occurs on the following edge while reset is held.
